// File: rtl/cmd_token_parser.sv
// cmd_token_parser
// ----------------
// Turns the UART receive byte stream into typed calculator tokens.
// Bytes arrive on a valid/ready handshake. Each byte is classified as a
// digit, an operator, equals, escape or ignorable. Digits accumulate into
// a multi-digit operand, in radix 10, or in radix 16 when HEX_EN is set.
// Tokens leave on a second valid/ready handshake. The legacy one-cycle
// got_* class pulses are still produced for the display and LED logic.
//
// Parameters
//   MAX_DIGITS : maximum digits per operand
//   HEX_EN     : 0 = radix 10; 1 = radix 16, which also accepts A-F and a-f
//   VAL_W      : operand width; 2**VAL_W must be >= RADIX**MAX_DIGITS
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   byte present
//   in_data    in   ASCII byte
//   in_ready   out  byte is accepted this cycle
//   tok_valid  out  token present
//   tok_ready  in   consumer takes the token
//   tok_type   out  0 NUM, 1 OP, 2 EQ, 3 ESC, 4 ERR
//   tok_val    out  operand value for NUM, otherwise 0
//   tok_op     out  operator code for OP (0 '+', 1 '-', 2 '*', 3 '/'), otherwise 0
//   got_dig, got_op, got_eq, got_esc
//              out  one-cycle class pulses, in the cycle after acceptance
//   digit_cnt  out  digits held in the operand in progress

module cmd_token_parser #(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned HEX_EN     = 0,
    parameter int unsigned VAL_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [7:0]                          in_data,
    output logic                                in_ready,
    output logic                                tok_valid,
    input  logic                                tok_ready,
    output logic [2:0]                          tok_type,
    output logic [VAL_W-1:0]                    tok_val,
    output logic [1:0]                          tok_op,
    output logic                                got_dig,
    output logic                                got_op,
    output logic                                got_eq,
    output logic                                got_esc,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_cnt
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam bit          HEX   = (HEX_EN != 0);
    localparam int unsigned RADIX = HEX ? 16 : 10;

    typedef enum logic [2:0] {
        TOK_NUM = 3'd0,
        TOK_OP  = 3'd1,
        TOK_EQ  = 3'd2,
        TOK_ESC = 3'd3,
        TOK_ERR = 3'd4
    } tok_type_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [VAL_W-1:0]    acc_q,   acc_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                ovf_q,   ovf_d;

    // Output token register
    logic                tv_q,    tv_d;
    tok_type_e           tt_q,    tt_d;
    logic [VAL_W-1:0]    tval_q,  tval_d;
    logic [1:0]          top_q,   top_d;

    // Second-token slot. An operator or equals that closes an operand
    // yields two tokens (NUM/ERR, then OP/EQ). The second one waits here
    // and moves into the output register on the first one's handshake.
    logic                pend_q,  pend_d;
    tok_type_e           ptype_q, ptype_d;
    logic [1:0]          pop_q,   pop_d;

    logic                gdig_q,  gdig_d;
    logic                gop_q,   gop_d;
    logic                geq_q,   geq_d;
    logic                gesc_q,  gesc_d;

    // ------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------
    logic                is_dig;
    logic                is_op;
    logic                is_eq;
    logic                is_esc;
    logic [3:0]          dig_val;
    logic [1:0]          op_code;

    always_comb begin
        is_dig  = 1'b0;
        is_op   = 1'b0;
        is_eq   = 1'b0;
        is_esc  = 1'b0;
        dig_val = '0;
        op_code = '0;

        if ((in_data >= 8'h30) && (in_data <= 8'h39)) begin
            is_dig  = 1'b1;
            dig_val = in_data[3:0];
        end else if (HEX && (((in_data >= 8'h41) && (in_data <= 8'h46)) ||
                             ((in_data >= 8'h61) && (in_data <= 8'h66)))) begin
            // 'A'/'a' have low nibble 1, so adding 9 gives the value 10..15
            is_dig  = 1'b1;
            dig_val = in_data[3:0] + 4'd9;
        end

        case (in_data)
            8'h2B: begin is_op = 1'b1; op_code = 2'd0; end
            8'h2D: begin is_op = 1'b1; op_code = 2'd1; end
            8'h2A: begin is_op = 1'b1; op_code = 2'd2; end
            8'h2F: begin is_op = 1'b1; op_code = 2'd3; end
            8'h3D, 8'h0D: is_eq  = 1'b1;
            8'h1B:        is_esc = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic accept;
    logic tok_hs;

    assign in_ready = !tv_q && !pend_q;
    assign accept   = in_valid && in_ready;
    assign tok_hs   = tv_q && tok_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        tv_d    = tv_q;
        tt_d    = tt_q;
        tval_d  = tval_q;
        top_d   = top_q;
        pend_d  = pend_q;
        ptype_d = ptype_q;
        pop_d   = pop_q;
        gdig_d  = 1'b0;
        gop_d   = 1'b0;
        geq_d   = 1'b0;
        gesc_d  = 1'b0;

        // accept and tok_hs never coincide: in_ready is low while tv_q is high
        if (tok_hs) begin
            if (pend_q) begin
                tv_d    = 1'b1;
                tt_d    = ptype_q;
                tval_d  = '0;
                top_d   = pop_q;
                pend_d  = 1'b0;
                ptype_d = TOK_NUM;
                pop_d   = '0;
            end else begin
                tv_d    = 1'b0;
                tt_d    = TOK_NUM;
                tval_d  = '0;
                top_d   = '0;
            end
        end else if (accept) begin
            gdig_d = is_dig;
            gop_d  = is_op;
            geq_d  = is_eq;
            gesc_d = is_esc;

            if (is_dig) begin
                if (state_q == S_IDLE) begin
                    acc_d   = VAL_W'(dig_val);
                    cnt_d   = CNT_W'(1);
                    state_d = S_ACC;
                end else if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                    acc_d   = acc_q * VAL_W'(RADIX) + VAL_W'(dig_val);
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    // Operand full: remember the overflow, keep the value
                    ovf_d   = 1'b1;
                end
            end else if (is_op || is_eq) begin
                tv_d = 1'b1;
                if (state_q == S_ACC) begin
                    tt_d    = ovf_q ? TOK_ERR : TOK_NUM;
                    tval_d  = ovf_q ? '0 : acc_q;
                    top_d   = '0;
                    pend_d  = 1'b1;
                    ptype_d = is_op ? TOK_OP : TOK_EQ;
                    pop_d   = is_op ? op_code : 2'd0;
                end else begin
                    tt_d    = is_op ? TOK_OP : TOK_EQ;
                    tval_d  = '0;
                    top_d   = is_op ? op_code : 2'd0;
                end
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = S_IDLE;
            end else if (is_esc) begin
                tv_d    = 1'b1;
                tt_d    = TOK_ESC;
                tval_d  = '0;
                top_d   = '0;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = S_IDLE;
            end
            // Any other byte is consumed silently
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            tv_q    <= 1'b0;
            tt_q    <= TOK_NUM;
            tval_q  <= '0;
            top_q   <= '0;
            pend_q  <= 1'b0;
            ptype_q <= TOK_NUM;
            pop_q   <= '0;
            gdig_q  <= 1'b0;
            gop_q   <= 1'b0;
            geq_q   <= 1'b0;
            gesc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            tv_q    <= tv_d;
            tt_q    <= tt_d;
            tval_q  <= tval_d;
            top_q   <= top_d;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            pop_q   <= pop_d;
            gdig_q  <= gdig_d;
            gop_q   <= gop_d;
            geq_q   <= geq_d;
            gesc_q  <= gesc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tok_valid = tv_q;
    assign tok_type  = tt_q;
    assign tok_val   = tval_q;
    assign tok_op    = top_q;
    assign got_dig   = gdig_q;
    assign got_op    = gop_q;
    assign got_eq    = geq_q;
    assign got_esc   = gesc_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_cmd_token_parser.sv
module tb_cmd_token_parser;

    localparam int MAXD = 4;

    localparam logic [2:0] T_NUM = 3'd0;
    localparam logic [2:0] T_OP  = 3'd1;
    localparam logic [2:0] T_EQ  = 3'd2;
    localparam logic [2:0] T_ESC = 3'd3;
    localparam logic [2:0] T_ERR = 3'd4;

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] v;
        logic [1:0]  op;
    } tok_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: decimal instance, index 1: hex instance
    logic        in_valid  [2];
    logic [7:0]  in_data   [2];
    logic        in_ready  [2];
    logic        tok_valid [2];
    logic        tok_ready [2];
    logic [2:0]  tok_type  [2];
    logic [15:0] tok_val   [2];
    logic [1:0]  tok_op    [2];
    logic        got_dig   [2];
    logic        got_op    [2];
    logic        got_eq    [2];
    logic        got_esc   [2];
    logic [2:0]  digit_cnt [2];

    cmd_token_parser #(.MAX_DIGITS(4), .HEX_EN(0), .VAL_W(16)) u_dec (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .tok_valid(tok_valid[0]), .tok_ready(tok_ready[0]), .tok_type(tok_type[0]),
        .tok_val(tok_val[0]), .tok_op(tok_op[0]),
        .got_dig(got_dig[0]), .got_op(got_op[0]), .got_eq(got_eq[0]), .got_esc(got_esc[0]),
        .digit_cnt(digit_cnt[0])
    );

    cmd_token_parser #(.MAX_DIGITS(4), .HEX_EN(1), .VAL_W(16)) u_hex (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .tok_valid(tok_valid[1]), .tok_ready(tok_ready[1]), .tok_type(tok_type[1]),
        .tok_val(tok_val[1]), .tok_op(tok_op[1]),
        .got_dig(got_dig[1]), .got_op(got_op[1]), .got_eq(got_eq[1]), .got_esc(got_esc[1]),
        .digit_cnt(digit_cnt[1])
    );

    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;

    logic [7:0] tx     [2][$];   // bytes still to be offered
    tok_t       expq   [2][$];   // tokens the model has produced, not yet taken
    tok_t       obs    [2][$];   // tokens actually taken, in order
    int         obs_cy [2][$];   // cycle of each take
    int         mdig   [2][$];   // digit values of the operand in progress
    bit         movf   [2];
    int         pc     [2][4];   // pulse counts: dig, op, eq, esc
    bit         vld_drv[2];
    bit         rdy_last[2];
    bit         hold   [2];
    tok_t       held   [2];
    int         rmode  [2];      // 0 always ready, 1 random, 2 stall while stall>0
    int         stall  [2];
    bit         gaps;

    task automatic chk(input string tag, input int d, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s dut%0d: observed 0x%0h expected 0x%0h", tag, d, obs_v, exp_v);
        end
    endtask

    function automatic tok_t mk(input logic [2:0] t, input logic [15:0] v, input logic [1:0] op);
        tok_t r;
        r.t  = t;
        r.v  = v;
        r.op = op;
        return r;
    endfunction

    // Behavioural model: operand kept as a list of digit values
    task automatic close_operand(input int d, input tok_t second);
        int radix = (d == 1) ? 16 : 10;
        int n     = mdig[d].size();
        int val   = 0;
        if (n > 0) begin
            for (int i = 0; i < n; i++) val += mdig[d][i] * (radix ** (n - 1 - i));
            if (movf[d]) expq[d].push_back(mk(T_ERR, 16'h0, 2'd0));
            else         expq[d].push_back(mk(T_NUM, 16'(val), 2'd0));
        end
        expq[d].push_back(second);
        mdig[d].delete();
        movf[d] = 1'b0;
    endtask

    task automatic feed(input int d, input logic [7:0] b, output logic [3:0] pulse);
        int dv = -1;
        pulse = 4'b0000;
        if (b >= 8'h30 && b <= 8'h39) dv = int'(b) - 'h30;
        else if (d == 1 && b >= 8'h41 && b <= 8'h46) dv = int'(b) - 'h41 + 10;
        else if (d == 1 && b >= 8'h61 && b <= 8'h66) dv = int'(b) - 'h61 + 10;

        if (dv >= 0) begin
            pulse = 4'b1000;
            if (mdig[d].size() < MAXD) mdig[d].push_back(dv);
            else                       movf[d] = 1'b1;
        end else if (b == 8'h2B) begin pulse = 4'b0100; close_operand(d, mk(T_OP, 16'h0, 2'd0)); end
        else if (b == 8'h2D) begin pulse = 4'b0100; close_operand(d, mk(T_OP, 16'h0, 2'd1)); end
        else if (b == 8'h2A) begin pulse = 4'b0100; close_operand(d, mk(T_OP, 16'h0, 2'd2)); end
        else if (b == 8'h2F) begin pulse = 4'b0100; close_operand(d, mk(T_OP, 16'h0, 2'd3)); end
        else if (b == 8'h3D || b == 8'h0D) begin pulse = 4'b0010; close_operand(d, mk(T_EQ, 16'h0, 2'd0)); end
        else if (b == 8'h1B) begin
            pulse = 4'b0001;
            mdig[d].delete();
            movf[d] = 1'b0;
            expq[d].push_back(mk(T_ESC, 16'h0, 2'd0));
        end
    endtask

    // One clock cycle: observe at the falling edge, then drive for the next rising edge
    task automatic cyc();
        logic [3:0] pexp;
        logic [7:0] b;
        tok_t       e;
        @(negedge clk);
        cycle++;
        for (int d = 0; d < 2; d++) begin
            pexp = 4'b0000;
            if (vld_drv[d] && rdy_last[d]) begin
                b = tx[d].pop_front();
                feed(d, b, pexp);
            end
            chk("got_pulses", d, 32'({got_dig[d], got_op[d], got_eq[d], got_esc[d]}), 32'(pexp));
            chk("digit_cnt", d, 32'(digit_cnt[d]), 32'(mdig[d].size()));
            chk("tok_valid", d, 32'(tok_valid[d]), 32'(expq[d].size() != 0));
            chk("in_ready", d, 32'(in_ready[d]), 32'(expq[d].size() == 0));
            if (hold[d]) chk("held_token", d, 32'({tok_type[d], tok_val[d], tok_op[d]}), 32'(held[d]));
            pc[d][0] += int'(got_dig[d]);
            pc[d][1] += int'(got_op[d]);
            pc[d][2] += int'(got_eq[d]);
            pc[d][3] += int'(got_esc[d]);

            case (rmode[d])
                0: tok_ready[d] = 1'b1;
                1: tok_ready[d] = ($urandom_range(0, 3) != 0);
                default: begin
                    if (tok_valid[d] && stall[d] > 0) begin
                        tok_ready[d] = 1'b0;
                        stall[d]--;
                    end else begin
                        tok_ready[d] = 1'b1;
                    end
                end
            endcase

            if (tok_valid[d] && tok_ready[d] && expq[d].size() != 0) begin
                e = expq[d].pop_front();
                chk("tok_type", d, 32'(tok_type[d]), 32'(e.t));
                chk("tok_val", d, 32'(tok_val[d]), 32'(e.v));
                chk("tok_op", d, 32'(tok_op[d]), 32'(e.op));
                obs[d].push_back(mk(tok_type[d], tok_val[d], tok_op[d]));
                obs_cy[d].push_back(cycle);
            end
            hold[d] = tok_valid[d] && !tok_ready[d];
            held[d] = mk(tok_type[d], tok_val[d], tok_op[d]);

            if (tx[d].size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid[d] = 1'b1;
                in_data[d]  = tx[d][0];
            end else begin
                in_valid[d] = 1'b0;
                in_data[d]  = 8'($urandom_range(0, 255));
            end
            vld_drv[d]  = in_valid[d];
            rdy_last[d] = in_ready[d];
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((tx[0].size() + tx[1].size() + expq[0].size() + expq[1].size()) != 0 && n < budget) begin
            cyc();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL drain_timeout: observed %0d cycles expected fewer than %0d", n, budget);
        end
        repeat (3) cyc();
    endtask

    task automatic reset_bench();
        for (int d = 0; d < 2; d++) begin
            tx[d].delete();
            expq[d].delete();
            mdig[d].delete();
            movf[d]      = 1'b0;
            vld_drv[d]   = 1'b0;
            rdy_last[d]  = 1'b0;
            hold[d]      = 1'b0;
            held[d]      = '0;
            rmode[d]     = 0;
            stall[d]     = 0;
            in_valid[d]  = 1'b0;
            in_data[d]   = 8'h00;
            tok_ready[d] = 1'b1;
        end
        gaps = 1'b0;
    endtask

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            obs[d].delete();
            obs_cy[d].delete();
            for (int k = 0; k < 4; k++) pc[d][k] = 0;
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_tok_valid"}, d, 32'(tok_valid[d]), 32'(0));
            chk({tag, "_tok_fields"}, d, 32'({tok_type[d], tok_val[d], tok_op[d]}), 32'(0));
            chk({tag, "_pulses"}, d, 32'({got_dig[d], got_op[d], got_eq[d], got_esc[d]}), 32'(0));
            chk({tag, "_digit_cnt"}, d, 32'(digit_cnt[d]), 32'(0));
            chk({tag, "_in_ready"}, d, 32'(in_ready[d]), 32'(1));
        end
    endtask

    task automatic chk_obs(input string tag, input int d, input int i,
                           input logic [2:0] t, input logic [15:0] v, input logic [1:0] op);
        tok_t o = '1;
        if (i < obs[d].size()) o = obs[d][i];
        chk({tag, "_type"}, d, 32'(o.t), 32'(t));
        chk({tag, "_val"}, d, 32'(o.v), 32'(v));
        chk({tag, "_op"}, d, 32'(o.op), 32'(op));
    endtask

    task automatic send(input int d, input string s);
        for (int i = 0; i < s.len(); i++) tx[d].push_back(8'(s[i]));
    endtask

    initial begin
        reset_bench();
        clear_obs();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        // Decimal: "12+7\r" -> NUM 12, OP 0, NUM 7, EQ
        clear_obs();
        send(0, "12+7");
        tx[0].push_back(8'h0D);
        drain(200);
        chk("dec_count", 0, 32'(obs[0].size()), 32'(4));
        chk_obs("dec0", 0, 0, T_NUM, 16'd12, 2'd0);
        chk_obs("dec1", 0, 1, T_OP,  16'd0,  2'd0);
        chk_obs("dec2", 0, 2, T_NUM, 16'd7,  2'd0);
        chk_obs("dec3", 0, 3, T_EQ,  16'd0,  2'd0);
        chk("dec_got_dig", 0, 32'(pc[0][0]), 32'(3));
        chk("dec_got_op", 0, 32'(pc[0][1]), 32'(1));
        chk("dec_got_eq", 0, 32'(pc[0][2]), 32'(1));

        // Overflow: "12345=" -> ERR, EQ
        clear_obs();
        send(0, "12345=");
        drain(200);
        chk("ovf_count", 0, 32'(obs[0].size()), 32'(2));
        chk_obs("ovf0", 0, 0, T_ERR, 16'd0, 2'd0);
        chk_obs("ovf1", 0, 1, T_EQ,  16'd0, 2'd0);

        // Hex: "fF0a*" -> NUM 0xFF0A, OP 2
        clear_obs();
        send(1, "fF0a*");
        drain(200);
        chk("hex_count", 1, 32'(obs[1].size()), 32'(2));
        chk_obs("hex0", 1, 0, T_NUM, 16'hFF0A, 2'd0);
        chk_obs("hex1", 1, 1, T_OP,  16'd0,    2'd2);

        // ESC mid-operand with an ignored byte, on both instances
        clear_obs();
        for (int d = 0; d < 2; d++) begin
            send(d, "9,");
            tx[d].push_back(8'h1B);
        end
        drain(200);
        for (int d = 0; d < 2; d++) begin
            chk("esc_count", d, 32'(obs[d].size()), 32'(1));
            chk_obs("esc0", d, 0, T_ESC, 16'd0, 2'd0);
            chk("esc_pulses", d, 32'(pc[d][0] + pc[d][1] + pc[d][2] + pc[d][3]), 32'(2));
            chk("esc_digit_cnt", d, 32'(digit_cnt[d]), 32'(0));
        end

        // Backpressure: consumer stalls 5 cycles on NUM 4
        clear_obs();
        rmode[0] = 2;
        stall[0] = 5;
        send(0, "4-");
        drain(200);
        chk("bp_count", 0, 32'(obs[0].size()), 32'(2));
        chk_obs("bp0", 0, 0, T_NUM, 16'd4, 2'd0);
        chk_obs("bp1", 0, 1, T_OP,  16'd0, 2'd1);
        if (obs_cy[0].size() == 2)
            chk("bp_gap", 0, 32'(obs_cy[0][1] - obs_cy[0][0]), 32'(1));
        rmode[0] = 0;

        // Asynchronous reset while the second-token slot holds an OP
        clear_obs();
        rmode[0] = 2;
        stall[0] = 1000;
        send(0, "8+");
        for (int n = 0; n < 50 && expq[0].size() != 2; n++) cyc();
        chk("pend_setup", 0, 32'(expq[0].size()), 32'(2));
        repeat (2) cyc();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset("async_reset");
        reset_bench();
        @(negedge clk);
        rst = 1'b1;
        send(0, "5=");
        drain(200);
        chk("post_reset_count", 0, 32'(obs[0].size()), 32'(2));
        chk_obs("post_reset0", 0, 0, T_NUM, 16'd5, 2'd0);
        chk_obs("post_reset1", 0, 1, T_EQ,  16'd0, 2'd0);

        // Random traffic on both instances with random backpressure and gaps
        clear_obs();
        rmode[0] = 1;
        rmode[1] = 1;
        gaps     = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 400; i++) begin
                int r = int'($urandom_range(0, 99));
                if (r < 40)      tx[d].push_back(8'(8'h30 + $urandom_range(0, 9)));
                else if (r < 50) tx[d].push_back(8'(($urandom_range(0, 1) != 0 ? 8'h41 : 8'h61) + $urandom_range(0, 5)));
                else if (r < 65) begin
                    case ($urandom_range(0, 3))
                        0: tx[d].push_back(8'h2B);
                        1: tx[d].push_back(8'h2D);
                        2: tx[d].push_back(8'h2A);
                        default: tx[d].push_back(8'h2F);
                    endcase
                end
                else if (r < 75) tx[d].push_back(($urandom_range(0, 1) != 0) ? 8'h3D : 8'h0D);
                else if (r < 79) tx[d].push_back(8'h1B);
                else             tx[d].push_back(8'($urandom_range(0, 255)));
            end
        end
        drain(20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
